// File: rtl/gate_selftest_ctrl.sv
// Self-test sequencer for the universal-gate bank: walks the four {A,B} vectors,
// lets each settle, and accumulates a sticky per-gate mismatch mask against a golden table.
//
// state  | meaning
// IDLE   | stimulus parked at 00, waiting for start
// SETTLE | vector driven, settle counter running down
// CHECK  | one cycle: gate_out compared against the expected word
// DONE   | one cycle: done pulse, pass reflects the finished run
module gate_selftest_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [11:0] gate_out,
    output logic        drv_a,
    output logic        drv_b,
    output logic [1:0]  vec_idx,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [11:0] fail_mask
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t      state;
    logic [7:0]  settle_cnt;
    logic [11:0] expected;
    logic [11:0] mask_next;
    logic [1:0]  vec_nxt;

    // Bit map: [5:0] NAND-built NOT(A),AND,OR,NOR,XOR,XNOR; [11:6] NOR-built NOT(B),AND,OR,NAND,XOR,XNOR.
    function automatic logic [11:0] golden(input logic a, input logic b);
        logic [11:0] g;
        g[0]  = ~a;
        g[1]  = a & b;
        g[2]  = a | b;
        g[3]  = ~(a | b);
        g[4]  = a ^ b;
        g[5]  = ~(a ^ b);
        g[6]  = ~b;
        g[7]  = a & b;
        g[8]  = a | b;
        g[9]  = ~(a & b);
        g[10] = a ^ b;
        g[11] = ~(a ^ b);
        return g;
    endfunction

    assign mask_next = fail_mask | (gate_out ^ expected);
    // Vector index v drives {A,B} = ~v, giving the 11,10,01,00 order.
    assign vec_nxt   = vec_idx + 2'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= 8'd0;
            expected   <= 12'd0;
            drv_a      <= 1'b0;
            drv_b      <= 1'b0;
            vec_idx    <= 2'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_mask  <= 12'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        fail_mask  <= 12'd0;
                        pass       <= 1'b0;
                        drv_a      <= 1'b1;
                        drv_b      <= 1'b1;
                        vec_idx    <= 2'd0;
                        expected   <= golden(1'b1, 1'b1);
                        settle_cnt <= SETTLE_LOAD;
                        busy       <= 1'b1;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        pass     <= 1'b0;
                        drv_a    <= 1'b0;
                        drv_b    <= 1'b0;
                        vec_idx  <= 2'd0;
                        expected <= golden(1'b0, 1'b0);
                    end else if (settle_cnt == 8'd0) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                CHECK: begin
                    // The compare still lands when aborting here, so the partial mask includes this vector.
                    fail_mask <= mask_next;
                    if (abort) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        pass     <= 1'b0;
                        drv_a    <= 1'b0;
                        drv_b    <= 1'b0;
                        vec_idx  <= 2'd0;
                        expected <= golden(1'b0, 1'b0);
                    end else if (vec_idx == 2'd3) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        pass     <= (mask_next == 12'd0);
                        drv_a    <= 1'b0;
                        drv_b    <= 1'b0;
                        vec_idx  <= 2'd0;
                        expected <= golden(1'b0, 1'b0);
                    end else begin
                        vec_idx    <= vec_nxt;
                        drv_a      <= ~vec_nxt[1];
                        drv_b      <= ~vec_nxt[0];
                        expected   <= golden(~vec_nxt[1], ~vec_nxt[0]);
                        settle_cnt <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Bench for gate_selftest_ctrl: three instances (settle 1, 2, 5) on a modelled gate bank
// with stuck-at and delay injection, checked every cycle against a run-time-based model.
module tb_gate_selftest_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  start, abort;
    logic [2:0]  drv_a, drv_b, busy, done, pass;
    logic [1:0]  vec_idx [3];
    logic [11:0] fail_mask [3];
    logic [11:0] gout [3];
    logic [11:0] gq [3];
    logic [11:0] st0 [3];
    logic [11:0] st1 [3];
    logic [2:0]  dly;

    int n_cmp = 0;
    int n_bad = 0;
    int lat [3];
    int dcnt;

    function automatic int s_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 5;
    endfunction

    // Truth table written as logical relations, MSB (bit 11) first.
    function automatic logic [11:0] golden(input logic a, input logic b);
        return {a == b, a != b, !(a && b), a || b, a && b, !b,
                a == b, a != b, !(a || b), a || b, a && b, !a};
    endfunction

    function automatic logic [11:0] golden_vec(input int v);
        return golden(v < 2, (v % 2) == 0);
    endfunction

    gate_selftest_ctrl #(.SETTLE_CYCLES(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .gate_out(gout[0]),
        .drv_a(drv_a[0]), .drv_b(drv_b[0]), .vec_idx(vec_idx[0]), .busy(busy[0]),
        .done(done[0]), .pass(pass[0]), .fail_mask(fail_mask[0]));
    gate_selftest_ctrl #(.SETTLE_CYCLES(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .gate_out(gout[1]),
        .drv_a(drv_a[1]), .drv_b(drv_b[1]), .vec_idx(vec_idx[1]), .busy(busy[1]),
        .done(done[1]), .pass(pass[1]), .fail_mask(fail_mask[1]));
    gate_selftest_ctrl #(.SETTLE_CYCLES(5)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]), .gate_out(gout[2]),
        .drv_a(drv_a[2]), .drv_b(drv_b[2]), .vec_idx(vec_idx[2]), .busy(busy[2]),
        .done(done[2]), .pass(pass[2]), .fail_mask(fail_mask[2]));

    // Gate bank: ideal or one-cycle-delayed gates, then stuck-at faults.
    always @(posedge clk) for (int i = 0; i < 3; i++) gq[i] <= golden(drv_a[i], drv_b[i]);
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            gout[i] = ((dly[i] ? gq[i] : golden(drv_a[i], drv_b[i])) & ~st0[i]) | st1[i];
        end
    end

    // Model: each run is just a count k of edges since the accepting edge.
    bit          chk_en = 1'b0;
    int          m_k [3];
    bit          m_run [3];
    bit          m_done [3];
    bit          m_pass [3];
    logic [11:0] m_mask [3];
    int          mper;
    bit          mwd;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_run[i] = 1'b0; m_done[i] = 1'b0; m_pass[i] = 1'b0;
                m_mask[i] = 12'd0; m_k[i] = 0;
            end else begin
                mper = s_of(i) + 1;
                mwd = m_done[i];
                m_done[i] = 1'b0;
                if (m_run[i]) begin
                    if ((m_k[i] + 1) % mper == 0)
                        m_mask[i] = m_mask[i] | (gout[i] ^ golden_vec(m_k[i] / mper));
                    if (abort[i]) begin
                        m_run[i] = 1'b0; m_pass[i] = 1'b0;
                    end else begin
                        m_k[i] = m_k[i] + 1;
                        if (m_k[i] == 4 * mper) begin
                            m_run[i] = 1'b0; m_done[i] = 1'b1;
                            m_pass[i] = (m_mask[i] == 12'd0);
                        end
                    end
                end else if (!mwd && start[i] && !abort[i]) begin
                    m_run[i] = 1'b1; m_k[i] = 0; m_mask[i] = 12'd0; m_pass[i] = 1'b0;
                end
            end
        end
        if (!rst_n) chk_en = 1'b1;
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, inst, $time, act, exp);
        end
    endtask

    int mv;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                mv = m_run[i] ? m_k[i] / (s_of(i) + 1) : 0;
                chk("busy", i, 32'(busy[i]), 32'(m_run[i]));
                chk("done", i, 32'(done[i]), 32'(m_done[i]));
                chk("pass", i, 32'(pass[i]), 32'(m_pass[i]));
                chk("fail_mask", i, 32'(fail_mask[i]), 32'(m_mask[i]));
                chk("vec_idx", i, 32'(vec_idx[i]), 32'(mv));
                chk("drv_a", i, 32'(drv_a[i]), 32'(m_run[i] && mv < 2));
                chk("drv_b", i, 32'(drv_b[i]), 32'(m_run[i] && (mv % 2) == 0));
            end
        end
    end

    task automatic run_sel(input logic [2:0] sel);
        for (int i = 0; i < 3; i++) lat[i] = 0;
        @(negedge clk); start = sel;
        @(posedge clk);
        @(negedge clk); start = 3'b000;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (sel[i] && done[i] && lat[i] == 0) lat[i] = n;
            if ((lat[0] != 0 || !sel[0]) && (lat[1] != 0 || !sel[1]) && (lat[2] != 0 || !sel[2])) break;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic set_faults(input logic [11:0] s0, input logic [11:0] s1);
        for (int i = 0; i < 3; i++) begin st0[i] = s0; st1[i] = s1; end
    endtask

    task automatic expect_all(input string nm, input logic [11:0] mask, input logic p);
        for (int i = 0; i < 3; i++) begin
            chk({nm, "_mask"}, i, 32'(fail_mask[i]), 32'(mask));
            chk({nm, "_pass"}, i, 32'(pass[i]), 32'(p));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 3'b000; abort = 3'b000; dly = 3'b000;
        set_faults(12'h000, 12'h000);
        repeat (2) @(negedge clk);
        chk("rst_busy", 1, 32'(busy[1]), 32'd0);
        chk("rst_mask", 1, 32'(fail_mask[1]), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Healthy bank, latency per settle setting.
        run_sel(3'b111);
        chk("lat", 0, 32'(lat[0]), 32'd8);
        chk("lat", 1, 32'(lat[1]), 32'd12);
        chk("lat", 2, 32'(lat[2]), 32'd24);
        expect_all("healthy", 12'h000, 1'b1);

        set_faults(12'h010, 12'h000);
        run_sel(3'b111);
        expect_all("xor_sa0", 12'h010, 1'b0);
        set_faults(12'h000, 12'h200);
        run_sel(3'b111);
        expect_all("nand_sa1", 12'h200, 1'b0);
        set_faults(12'h010, 12'h200);
        run_sel(3'b111);
        expect_all("both", 12'h210, 1'b0);

        // Abort on the second CHECK: bit9 fails on vector 0, bit0 only on vectors 2-3.
        set_faults(12'h001, 12'h200);
        @(negedge clk); start = 3'b010;
        @(posedge clk);
        @(negedge clk); start = 3'b000;
        repeat (5) @(posedge clk);
        @(negedge clk); abort = 3'b010;
        @(posedge clk);
        @(negedge clk); abort = 3'b000;
        chk("abort_busy", 1, 32'(busy[1]), 32'd0);
        chk("abort_mask", 1, 32'(fail_mask[1]), 32'h200);
        chk("abort_pass", 1, 32'(pass[1]), 32'd0);
        dcnt = 0;
        repeat (20) begin @(negedge clk); if (done[1]) dcnt++; end
        chk("abort_nodone", 1, 32'(dcnt), 32'd0);
        run_sel(3'b111);
        expect_all("full", 12'h201, 1'b0);

        // Reset during vector 2 settle.
        @(negedge clk); start = 3'b010;
        @(posedge clk);
        @(negedge clk); start = 3'b000;
        repeat (6) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_drv", 1, 32'({drv_a[1], drv_b[1], vec_idx[1]}), 32'd0);
        chk("rst_flags", 1, 32'({busy[1], done[1], pass[1]}), 32'd0);
        chk("rst_mask2", 1, 32'(fail_mask[1]), 32'd0);
        rst_n = 1'b1;
        set_faults(12'h000, 12'h000);
        run_sel(3'b010);
        chk("post_rst_lat", 1, 32'(lat[1]), 32'd12);
        chk("post_rst_pass", 1, 32'(pass[1]), 32'd1);

        // start held high: one run per IDLE visit.
        dcnt = 0;
        @(negedge clk); start = 3'b010;
        repeat (30) begin @(posedge clk); @(negedge clk); if (done[1]) dcnt++; end
        start = 3'b000;
        chk("held_runs", 1, 32'(dcnt), 32'd2);
        repeat (30) @(negedge clk);

        // Bank with one-cycle propagation delay.
        dly = 3'b111;
        run_sel(3'b111);
        chk("dly_lat", 0, 32'(lat[0]), 32'd8);
        expect_all("delayed", 12'h000, 1'b1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
